imem_fetch_ctrl: RTL and testbench

Direct-mapped instruction-cache controller between the PC register and the 128-bit-block instruction memory in the IF stage. It serves 32-bit instructions to the IF/ID register on a hit in the same cycle. On a miss it stalls the PC through `BUSYWAIT`, sequences a block read from instruction memory and fills the line. It replaces the always-reading direct connection of the PC to memory.

---
 rtl/imem_fetch_ctrl.sv | 139 +++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Direct-mapped instruction cache controller for the IF stage: same-cycle hits, block refill on miss.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module imem_fetch_ctrl #(
    parameter int unsigned LINES = 8,
    parameter int unsigned IDX_W = $clog2(LINES)
) (
    input  logic         CLOCK,
    input  logic         RESET,
    input  logic [31:0]  PC,
    output logic [31:0]  INSTRUCTION,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic [27:0]  MEM_ADDRESS,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]  HIT_COUNT,
    output logic [31:0]  MISS_COUNT
`endif
);

    localparam int unsigned BLK_W  = 28;
    localparam int unsigned TAG_W  = BLK_W - IDX_W;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LINE_W = 128;
    localparam logic [WORD_W-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t              state;
    logic [LINES-1:0]    valid;
    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [LINE_W-1:0]   data_mem [LINES];
    logic [BLK_W-1:0]    miss_addr;
    logic [LINE_W-1:0]   fill_data;

    logic [IDX_W-1:0]    pc_idx;
    logic [TAG_W-1:0]    pc_tag;
    logic [1:0]          pc_off;
    logic [IDX_W-1:0]    fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic                hit;
    logic                unused_pc_bits;

    // Byte address split into tag / index / word offset
    assign pc_off         = PC[3:2];
    assign pc_idx         = PC[4 +: IDX_W];
    assign pc_tag         = PC[31 -: TAG_W];
    assign fill_idx       = miss_addr[IDX_W-1:0];
    assign fill_tag       = miss_addr[BLK_W-1 -: TAG_W];
    assign hit            = valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    assign unused_pc_bits = ^PC[1:0];

    // Controller state, valid bits and miss bookkeeping
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            valid     <= '0;
            miss_addr <= '0;
            fill_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!hit) begin
                        miss_addr <= PC[31:4];
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (!MEM_BUSYWAIT) begin
                        fill_data <= MEM_READDATA;
                        state     <= UPDATE;
                    end
                end
                UPDATE: begin
                    valid[fill_idx] <= 1'b1;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; only the valid bits qualify them
    always_ff @(posedge CLOCK) begin
        if (state == UPDATE) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= fill_data;
        end
    end

    // Hit data, stall and memory request decode
    always_comb begin
        INSTRUCTION = NOP;
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b0;
        MEM_ADDRESS = '0;
        if (RESET) begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        INSTRUCTION = data_mem[pc_idx][{pc_off, 5'b0} +: WORD_W];
                        BUSYWAIT    = 1'b0;
                    end
                end
                FETCH: begin
                    MEM_READ    = 1'b1;
                    MEM_ADDRESS = miss_addr;
                end
                default: ;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    logic first_after_fill;

    // The cycle right after a fill is the replayed access, not a fresh hit
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            first_after_fill <= 1'b0;
            HIT_COUNT        <= '0;
            MISS_COUNT       <= '0;
        end else begin
            first_after_fill <= (state == UPDATE);
            if (state == IDLE && !hit)
                MISS_COUNT <= MISS_COUNT + 32'd1;
            if (state == IDLE && hit && !first_after_fill)
                HIT_COUNT <= HIT_COUNT + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed self-checking bench for imem_fetch_ctrl with a small latency-programmable block memory model.
module tb_imem_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] W0  = 32'h0010_0013;
    localparam logic [31:0] W1  = 32'h0030_0113;
    localparam logic [31:0] W2  = 32'h0050_0093;
    localparam logic [31:0] W3  = 32'h0070_0193;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [31:0]  pc = 32'h0;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [27:0]  mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
`ifdef ICACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int total  = 0;
    int passed = 0;
    int mem_lat = 5;
    int mem_cnt;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(.LINES(8)) dut (
        .CLOCK        (clk),
        .RESET        (rst_n),
        .PC           (pc),
        .INSTRUCTION  (instruction),
        .BUSYWAIT     (busywait),
        .MEM_READ     (mem_read),
        .MEM_ADDRESS  (mem_address),
        .MEM_READDATA (mem_readdata),
        .MEM_BUSYWAIT (mem_busywait)
`ifdef ICACHE_STATS_EN
        ,
        .HIT_COUNT    (hit_count),
        .MISS_COUNT   (miss_count)
`endif
    );

    // Memory with latency N: busy for N-1 request cycles, block delivered in the Nth
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        mem_cnt <= 0;
        else if (mem_read) mem_cnt <= mem_cnt + 1;
        else               mem_cnt <= 0;
    end
    assign mem_busywait = mem_read && (mem_cnt < mem_lat - 1);

    always_comb begin
        mem_readdata = '0;
        if (mem_address == 28'h0) begin
            mem_readdata = {W3, W2, W1, W0};
        end else begin
            for (int k = 0; k < 4; k++)
                mem_readdata[32*k +: 32] = {4'hB, mem_address[23:0], 4'(k)};
        end
    end

    task automatic test_reset();
        mem_lat = 5;
        pc = 32'h0;
        #1 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++; if (busywait !== 1'b1) $display("FAIL reset_busywait got=%b exp=1", busywait); else passed++;
            total++; if (mem_read !== 1'b0) $display("FAIL reset_mem_read got=%b exp=0", mem_read); else passed++;
            total++; if (instruction !== NOP) $display("FAIL reset_instr got=%h exp=%h", instruction, NOP); else passed++;
        end
        @(posedge clk); #1;
        pc = 32'h8;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (busywait !== 1'b1) $display("FAIL reset_first_miss got=%b exp=1", busywait); else passed++;
        total++; if (instruction !== NOP) $display("FAIL reset_first_nop got=%h exp=%h", instruction, NOP); else passed++;
    endtask

    task automatic test_cold_miss();
        int n;
        logic [27:0] seen_addr;
        n = 0;
        seen_addr = 28'hFFF_FFFF;
        for (int i = 0; i < 50; i++) begin
            if (!busywait) break;
            n++;
            if (mem_read) seen_addr = mem_address;
            @(negedge clk);
        end
        total++; if (n !== 7) $display("FAIL cold_busy_cycles got=%0d exp=7", n); else passed++;
        total++; if (seen_addr !== 28'h0) $display("FAIL cold_mem_address got=%h exp=0000000", seen_addr); else passed++;
        total++; if (instruction !== W2) $display("FAIL cold_instr got=%h exp=%h", instruction, W2); else passed++;
        total++; if (busywait !== 1'b0) $display("FAIL cold_busywait got=%b exp=0", busywait); else passed++;
    endtask

    task automatic test_seq_hits();
        logic [31:0] exp_w [4];
        exp_w = '{W0, W1, W2, W3};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            pc = 32'(4 * i);
            @(negedge clk);
            total++; if (instruction !== exp_w[i]) $display("FAIL seq_instr_%0d got=%h exp=%h", i, instruction, exp_w[i]); else passed++;
            total++; if (busywait !== 1'b0) $display("FAIL seq_busywait_%0d got=%b exp=0", i, busywait); else passed++;
            total++; if (mem_read !== 1'b0) $display("FAIL seq_mem_read_%0d got=%b exp=0", i, mem_read); else passed++;
        end
`ifdef ICACHE_STATS_EN
        @(negedge clk);
        total++; if (miss_count !== 32'd1) $display("FAIL stats_miss got=%0d exp=1", miss_count); else passed++;
        total++; if (hit_count !== 32'd4) $display("FAIL stats_hit got=%0d exp=4", hit_count); else passed++;
`endif
    endtask

    task automatic test_conflict();
        logic [27:0] seen_addr;
        mem_lat = 2;
        @(posedge clk); #1;
        pc = 32'h80;
        @(negedge clk);
        total++; if (busywait !== 1'b1) $display("FAIL conflict_miss got=%b exp=1", busywait); else passed++;
        seen_addr = 28'hFFF_FFFF;
        for (int i = 0; i < 50; i++) begin
            if (!busywait) break;
            if (mem_read) seen_addr = mem_address;
            @(negedge clk);
        end
        total++; if (busywait !== 1'b0) $display("FAIL conflict_fill_done got=%b exp=0", busywait); else passed++;
        total++; if (seen_addr !== 28'h8) $display("FAIL conflict_mem_address got=%h exp=0000008", seen_addr); else passed++;
        total++; if (instruction !== 32'hB000_0080) $display("FAIL conflict_instr got=%h exp=b0000080", instruction); else passed++;
        @(posedge clk); #1;
        pc = 32'h0;
        @(negedge clk);
        total++; if (busywait !== 1'b1) $display("FAIL evicted_miss got=%b exp=1", busywait); else passed++;
        for (int i = 0; i < 50; i++) begin
            if (!busywait) break;
            @(negedge clk);
        end
        total++; if (instruction !== W0) $display("FAIL evicted_refill got=%h exp=%h", instruction, W0); else passed++;
    endtask

    task automatic test_reset_mid_fetch();
        logic [27:0] seen_addr;
        mem_lat = 10;
        @(posedge clk); #1;
        pc = 32'h40;
        @(negedge clk);
        total++; if (busywait !== 1'b1) $display("FAIL midrst_miss got=%b exp=1", busywait); else passed++;
        repeat (4) @(posedge clk);
        #1;
        total++; if (mem_read !== 1'b1) $display("FAIL midrst_fetch4_read got=%b exp=1", mem_read); else passed++;
        total++; if (mem_address !== 28'h4) $display("FAIL midrst_fetch4_addr got=%h exp=0000004", mem_address); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (mem_read !== 1'b0) $display("FAIL midrst_read_drop got=%b exp=0", mem_read); else passed++;
        total++; if (mem_address !== 28'h0) $display("FAIL midrst_addr_clear got=%h exp=0000000", mem_address); else passed++;
        total++; if (busywait !== 1'b1) $display("FAIL midrst_busywait got=%b exp=1", busywait); else passed++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (busywait !== 1'b1) $display("FAIL midrst_remiss got=%b exp=1", busywait); else passed++;
        seen_addr = 28'hFFF_FFFF;
        for (int i = 0; i < 50; i++) begin
            if (!busywait) break;
            if (mem_read) seen_addr = mem_address;
            @(negedge clk);
        end
        total++; if (seen_addr !== 28'h4) $display("FAIL midrst_refetch_addr got=%h exp=0000004", seen_addr); else passed++;
        total++; if (instruction !== 32'hB000_0040) $display("FAIL midrst_refill got=%h exp=b0000040", instruction); else passed++;
        // Block 0 was filled before the reset, so it must have been invalidated
        @(posedge clk); #1;
        pc = 32'h0;
        @(negedge clk);
        total++; if (busywait !== 1'b1) $display("FAIL midrst_blk0_invalid got=%b exp=1", busywait); else passed++;
        for (int i = 0; i < 50; i++) begin
            if (!busywait) break;
            @(negedge clk);
        end
        total++; if (instruction !== W0) $display("FAIL midrst_blk0_refill got=%h exp=%h", instruction, W0); else passed++;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_seq_hits();
        test_conflict();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
